sign_extend: RTL and testbench

SIGN_EXTEND -- requirements
Module: sign_extend

---
 rtl/sign_extend.sv | 59 +++++
 tb/tb_sign_extend.sv | 137 +++++++++++++
 2 files changed

// File: rtl/sign_extend.sv
// ============================================================================
// Module   : sign_extend
// Purpose  : registered RV32I immediate decoder (I/S/B/J formats); the
//            optional U-format override is enabled by the SE_UTYPE_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sign_extend #(
   parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic [1:0]  src,
`ifdef SE_UTYPE_EN
   input  logic        utype,
`endif
   output logic [31:0] immExt
);

   localparam logic [1:0] SRC_I = 2'b00;
   localparam logic [1:0] SRC_S = 2'b01;
   localparam logic [1:0] SRC_B = 2'b10;
   localparam logic [1:0] SRC_J = 2'b11;

   logic [31:0] imm_next;
   logic        sign;

   assign sign = instr[31];

   always_comb begin
      imm_next = {{20{sign}}, instr[31:20]};
      case (src)
         SRC_I: imm_next = {{20{sign}}, instr[31:20]};
         SRC_S: imm_next = {{20{sign}}, instr[31:25], instr[11:7]};
         SRC_B: imm_next = {{19{sign}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         SRC_J: imm_next = {{11{sign}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm_next = {{20{sign}}, instr[31:20]};
      endcase
`ifdef SE_UTYPE_EN
      // U-format wins over the src selection
      if (utype) begin
         imm_next = {instr[31:12], 12'b0};
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         immExt <= RST_VAL;
      end else begin
         immExt <= imm_next;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sign_extend.sv
// ============================================================================
// Module   : tb_sign_extend
// Purpose  : directed self-checking bench for sign_extend
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sign_extend;

   logic        clk;
   logic        rst_n;
   logic [31:0] instr;
   logic [1:0]  src;
   logic [31:0] immExt;
`ifdef SE_UTYPE_EN
   logic        utype;
`endif

   int checks;
   int errors;

   sign_extend #(
      .RST_VAL (32'h0000_0000)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .instr  (instr),
      .src    (src),
`ifdef SE_UTYPE_EN
      .utype  (utype),
`endif
      .immExt (immExt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive on the falling edge, let one rising edge load, sample 1 ns later.
   task automatic step(input logic rn, input logic [31:0] ins, input logic [1:0] s);
      @(negedge clk);
      rst_n = rn;
      instr = ins;
      src   = s;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] expected);
      checks++;
      assert (immExt === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, immExt, expected);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      instr  = 32'hDEAD_BEEF;
      src    = 2'b11;
`ifdef SE_UTYPE_EN
      utype  = 1'b1;
`endif

      step(1'b0, 32'hDEAD_BEEF, 2'b11);
      step(1'b0, 32'hFFFF_FFFF, 2'b10);
      check("reset_2_edges", 32'h0000_0000);
`ifdef SE_UTYPE_EN
      @(negedge clk);
      utype = 1'b0;
`endif

      step(1'b1, 32'hA750_0000, 2'b00);
      check("i_neg", 32'hFFFF_FA75);
      step(1'b1, 32'hA600_0A80, 2'b01);
      check("s_neg", 32'hFFFF_FA75);
      step(1'b1, 32'hA600_0A80, 2'b10);
      check("b_neg", 32'hFFFF_FA74);
      step(1'b1, 32'hA600_0A80, 2'b11);
      check("j_neg", 32'hFFF0_0260);
      step(1'b1, 32'h0010_0000, 2'b00);
      check("i_pos_one", 32'h0000_0001);
      step(1'b1, 32'hA750_007F, 2'b00);
      check("i_opcode_ignored", 32'hFFFF_FA75);
      step(1'b1, 32'h7FF0_0000, 2'b00);
      check("i_pos_max", 32'h0000_07FF);
      step(1'b1, 32'h8000_0000, 2'b11);
      check("j_sign_only", 32'hFFF0_0000);
      step(1'b1, 32'h0000_0F80, 2'b01);
      check("s_low_bits", 32'h0000_001F);
      step(1'b1, 32'h0000_0080, 2'b10);
      check("b_bit11", 32'h0000_0800);

      // Format sequence with reset pulsed on the third edge
      step(1'b1, 32'hA600_0A80, 2'b00);
      check("seq_i", 32'hFFFF_FA60);
      step(1'b1, 32'hA600_0A80, 2'b01);
      check("seq_s", 32'hFFFF_FA75);
      step(1'b0, 32'hA600_0A80, 2'b10);
      check("seq_reset", 32'h0000_0000);
      step(1'b1, 32'hA600_0A80, 2'b11);
      check("seq_j_after_reset", 32'hFFF0_0260);
      step(1'b1, 32'hA600_0A80, 2'b10);
      check("seq_b", 32'hFFFF_FA74);

`ifdef SE_UTYPE_EN
      for (int s = 0; s < 4; s++) begin
         @(negedge clk);
         utype = 1'b1;
         step(1'b1, 32'hA600_0A80, 2'(s));
         check("utype", 32'hA600_0000);
      end
      @(negedge clk);
      utype = 1'b0;
      step(1'b1, 32'hA600_0A80, 2'b11);
      check("utype_off_j", 32'hFFF0_0260);
      @(negedge clk);
      utype = 1'b1;
      step(1'b0, 32'hA600_0A80, 2'b00);
      check("utype_reset", 32'h0000_0000);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
